sdram_cmd_responder: RTL and testbench
======================================

SDRAM_CMD_RESPONDER -- requirements
Module: sdram_cmd_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16 (power of 2, >=4), write-buffer words.
REQ-004 SHALL have parameter INIT_CYCLES, default 20000, post-reset init wait in clk cycles.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port sdram_cmd  in  1  master op active; burst lasts while high.
REQ-008 SHALL have port sdram_we  in  1  1 = write burst, 0 = read burst; sampled with sdram_cmd.
REQ-009 SHALL have port sdram_addr  in  ADDR_W  burst start address, captured at burst start.
REQ-010 SHALL have port sdram_data  in  DATA_W  write beat data.
REQ-011 SHALL have port stall  out  1  registered; beats are not accepted while high.
REQ-012 SHALL have port ready  out  1  init complete.
REQ-013 SHALL have port rd_data  out  DATA_W  read return data.
REQ-014 SHALL have port rd_valid  out  1  one-cycle pulse per returned word.
REQ-015 SHALL have ports mem_req/mem_we (out 1), mem_addr (out ADDR_W), mem_wdata (out DATA_W), mem_ack (in 1), mem_rdata (in DATA_W): backend; one word per req/ack pair; req held until ack.

Function
REQ-016 SHALL implement states INIT, IDLE, WRITE, READ.
REQ-017 INIT: count INIT_CYCLES, then ready=1 and go to IDLE; stall=1 throughout INIT.
REQ-018 IDLE, sdram_cmd=1, sdram_we=1: capture sdram_addr into the address counter and go to WRITE.
REQ-019 IDLE, sdram_cmd=1, sdram_we=0: capture address and hold stall=1 until the FIFO is empty (read-after-write ordering), then go to READ.
REQ-020 WRITE: a beat is accepted in each cycle with sdram_cmd=1 and stall=0; the word is pushed with its current address and the address increments by 1.
REQ-021 stall SHALL rise when FIFO occupancy >= FIFO_DEPTH-2, so one beat accepted on the rising cycle still fits; overflow SHALL never occur.
REQ-022 WRITE: sdram_cmd=0 returns to IDLE next cycle; buffered words continue to drain.
REQ-023 Drain: when the FIFO is non-empty and the backend is idle, issue mem_req=1, mem_we=1 with head addr/data; pop on mem_ack.
REQ-024 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-025 READ: while sdram_cmd=1, issue sequential mem_req=1, mem_we=0 at incrementing addresses; on mem_ack, rd_data<=mem_rdata and rd_valid=1 for one cycle.
REQ-026 READ: sdram_cmd falling with a request outstanding SHALL complete that request and return its word with rd_valid, then go to IDLE; no new request is issued.
REQ-027 Address increment SHALL wrap from all-ones to 0 (ADDR_W bits).
REQ-028 Latency: rd_valid SHALL occur exactly 1 cycle after the mem_ack that returns the word.

Reset
REQ-029 reset=0 SHALL asynchronously force: state INIT, init counter loaded, FIFO empty, stall=1, ready=0, rd_valid=0, rd_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset mid-burst SHALL discard buffered and outstanding words; a late mem_ack after reset is ignored.

Configuration
REQ-031 With SDRAM_RESP_PAGE_WRAP_EN defined, the address increment SHALL wrap within a 1024-word page (low 10 bits wrap, upper bits held); without it, REQ-027 applies.

Structure
REQ-032 A shared package sdram_resp_pkg SHALL hold the state enum, default widths and the page size constant.
REQ-033 The write buffer SHALL be a sub-module sdram_resp_fifo (sync FIFO, {addr,data} words, count output).

Verification
REQ-034 Reset release -> ready=1 and stall=0 exactly INIT_CYCLES cycles later (INIT_CYCLES=20 in bench).
REQ-035 Write burst of 8 at addr 0x000100, data 1..8, mem_ack always 1 -> 8 backend writes at 0x100..0x107 with data 1..8 in order.
REQ-036 Write burst of 20, mem_ack held 0 -> stall rises at occupancy 14, no word lost; release ack -> all 20 words written.
REQ-037 Write 4 words at 0x10 then immediate read of 4 at 0x10 -> stall held until FIFO empty; rd_valid x4 returns the written data.
REQ-038 Read at 0xFFFFFE for 3 words -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000 (with the macro: 0xFFFFFE, 0xFFFFFF, 0xFFFC00).
REQ-039 reset=0 asserted mid-write burst with 5 words buffered -> no further mem_req; FIFO empty; outputs at reset values.

Source files
------------

// File: rtl/sdram_resp_pkg.sv
// sdram_resp_pkg: shared types and constants for the SDRAM command responder.
//   state_e        responder FSM states
//   DEF_*          default parameter values
//   PAGE_WORDS     page size used when page-wrap addressing is enabled
//   PAGE_WRAP_EN   1 when SDRAM_RESP_PAGE_WRAP_EN is defined: burst addresses
//                  wrap inside a PAGE_WORDS page instead of the full address space
package sdram_resp_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  localparam int unsigned DEF_ADDR_W      = 24;
  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_FIFO_DEPTH  = 16;
  localparam int unsigned DEF_INIT_CYCLES = 20000;

  localparam int unsigned PAGE_WORDS = 1024;

`ifdef SDRAM_RESP_PAGE_WRAP_EN
  localparam bit PAGE_WRAP_EN = 1'b1;
`else
  localparam bit PAGE_WRAP_EN = 1'b0;
`endif

endpackage

// File: rtl/sdram_cmd_responder_if.sv
// sdram_cmd_responder_if: host command bus plus backend word bus.
//   host side : sdram_cmd, sdram_we, sdram_addr, sdram_data -> responder
//               stall, ready, rd_data, rd_valid             <- responder
//   backend   : mem_req, mem_we, mem_addr, mem_wdata        -> memory
//               mem_ack, mem_rdata                          <- memory
// Modports: master (host), slave (responder), backend (memory).
interface sdram_cmd_responder_if
  import sdram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              sdram_cmd;
  logic              sdram_we;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_data;
  logic              stall;
  logic              ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output sdram_cmd, sdram_we, sdram_addr, sdram_data,
    input  stall, ready, rd_data, rd_valid
  );

  modport slave (
    input  sdram_cmd, sdram_we, sdram_addr, sdram_data,
    output stall, ready, rd_data, rd_valid,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport backend (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/sdram_resp_fifo.sv
// sdram_resp_fifo: synchronous write buffer holding {addr, data} words.
//   clk, reset           clock, async active-low reset (clears to empty)
//   push/push_addr/data  write one word (caller guarantees not full)
//   pop                  drop the head word (caller guarantees not empty)
//   head_addr/head_data  current head word (valid when !empty)
//   count, empty         occupancy
module sdram_resp_fifo #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned AW    = 24,
  parameter  int unsigned DW    = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [AW-1:0]    push_addr,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic [AW-1:0]    head_addr,
  output logic [DW-1:0]    head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [AW+DW-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_addr, push_data};
  end

  assign {head_addr, head_data} = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/sdram_cmd_responder.sv
// sdram_cmd_responder: SDRAM-style burst command responder with a posted
// write buffer and a one-word-at-a-time backend.
//   clk     sole clock, all logic on posedge
//   reset   asynchronous active-low reset
//   bus     sdram_cmd_responder_if.slave: host burst bus + backend word bus
// A write burst's first beat is accepted in the IDLE cycle that starts it
// (if stall is low); subsequent beats in WRITE. Reads wait for the write
// buffer to empty so they observe earlier writes.
// Build option: define SDRAM_RESP_PAGE_WRAP_EN to wrap burst addresses within
// a PAGE_WORDS page (see sdram_resp_pkg).
module sdram_cmd_responder
  import sdram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned INIT_CYCLES = DEF_INIT_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_cmd_responder_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 2);
  localparam logic [ADDR_W-1:0] WRAP_MASK =
    PAGE_WRAP_EN ? ADDR_W'(PAGE_WORDS - 1) : {ADDR_W{1'b1}};
  localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(FIFO_DEPTH - 2);

  // Bits under WRAP_MASK count; bits above it are held.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] a_inc;
    a_inc    = a + ADDR_W'(1);
    addr_inc = (a & ~WRAP_MASK) | (a_inc & WRAP_MASK);
  endfunction

  state_e            state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic              stall_q, stall_d;
  logic              ready_q, ready_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              fifo_push, fifo_pop, fifo_empty;
  logic [ADDR_W-1:0] fifo_push_addr, head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  fifo_count, fifo_count_nxt;
  logic              mem_done;

  sdram_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (ADDR_W),
    .DW    (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_addr (fifo_push_addr),
    .push_data (bus.sdram_data),
    .pop       (fifo_pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Next-state, backend sequencing and registered output values.
  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    addr_cnt_d     = addr_cnt_q;
    ready_d        = ready_q;
    rd_valid_d     = 1'b0;
    rd_data_d      = rd_data_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    fifo_push      = 1'b0;
    fifo_pop       = 1'b0;
    fifo_push_addr = addr_cnt_q;

    // Acks are only meaningful while a request is held.
    mem_done = mem_req_q & bus.mem_ack;
    if (mem_done) begin
      mem_req_d = 1'b0;
      if (mem_we_q) begin
        fifo_pop = 1'b1;
      end else begin
        rd_valid_d = 1'b1;
        rd_data_d  = bus.mem_rdata;
      end
    end

    // Drain buffered writes whenever the backend is free.
    if (!mem_req_q && !fifo_empty) begin
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = head_addr;
      mem_wdata_d = head_data;
    end

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q <= INIT_W'(1)) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q - INIT_W'(1);
        end
      end
      ST_IDLE: begin
        if (bus.sdram_cmd) begin
          addr_cnt_d = bus.sdram_addr;
          if (bus.sdram_we) begin
            state_d = ST_WRITE;
            if (!stall_q) begin
              fifo_push      = 1'b1;
              fifo_push_addr = bus.sdram_addr;
              addr_cnt_d     = addr_inc(bus.sdram_addr);
            end
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        if (!bus.sdram_cmd) begin
          state_d = ST_IDLE;
        end else if (bus.sdram_we && !stall_q) begin
          fifo_push  = 1'b1;
          addr_cnt_d = addr_inc(addr_cnt_q);
        end
      end
      ST_READ: begin
        if (!bus.sdram_cmd) begin
          // Let an in-flight read finish; issue nothing new.
          if (!mem_req_q || mem_done) state_d = ST_IDLE;
        end else if (fifo_empty && !mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = addr_cnt_q;
          addr_cnt_d = addr_inc(addr_cnt_q);
        end
      end
      default: state_d = ST_INIT;
    endcase

    fifo_count_nxt = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

    // Threshold uses current occupancy, so the beat taken on the edge that
    // raises stall still has a free slot.
    stall_d = (state_d == ST_INIT) ||
              (fifo_count >= STALL_LVL) ||
              ((state_d == ST_READ) && (fifo_count_nxt != '0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= INIT_W'(INIT_CYCLES);
      addr_cnt_q  <= '0;
      stall_q     <= 1'b1;
      ready_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      addr_cnt_q  <= addr_cnt_d;
      stall_q     <= stall_d;
      ready_q     <= ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.stall     = stall_q;
  assign bus.ready     = ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// tb_sdram_cmd_responder: directed stimulus with a scoreboard. Stimulus pushes
// expected backend transactions and read data; a monitor pops and compares
// whenever the DUT completes a backend word or pulses rd_valid.
module tb_sdram_cmd_responder;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned INIT_C = 20;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_txn_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sdram_cmd_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_cmd_responder #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (DEPTH),
    .INIT_CYCLES (INIT_C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int wr_acc       = 0;

  mem_txn_t          exp_mem_q[$];
  logic [DATA_W-1:0] exp_rd_q[$];

  // Backend memory model: unwritten words read as 0xC000 | addr[9:0].
  logic              ack_en;
  logic              mdl_clr;
  logic [9:0]        mdl_idx;
  logic [DATA_W-1:0] mdl_mem [0:1023];
  logic [1023:0]     wr_mask;

  assign mdl_idx       = bus.mem_addr[9:0];
  assign bus.mem_ack   = ack_en;
  assign bus.mem_rdata = wr_mask[mdl_idx] ? mdl_mem[mdl_idx] : (16'hC000 | 16'(mdl_idx));

  always @(posedge clk) begin
    if (mdl_clr) begin
      wr_mask <= '0;
    end else if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
      mdl_mem[mdl_idx] <= bus.mem_wdata;
      wr_mask[mdl_idx] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compare every completed backend word and every returned read word.
  logic prev_rd_ack = 1'b0;
  initial begin
    mem_txn_t          e;
    logic [DATA_W-1:0] d;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_rd_ack = 1'b0;
      end else begin
        if (prev_rd_ack || bus.rd_valid)
          chk("rd_latency", 32'(bus.rd_valid), 32'(prev_rd_ack));
        if (bus.rd_valid) begin
          if (exp_rd_q.size() == 0) begin
            fail_now("rd_unexpected");
          end else begin
            d = exp_rd_q.pop_front();
            chk("rd_data", 32'(bus.rd_data), 32'(d));
          end
        end
        prev_rd_ack = bus.mem_req && bus.mem_ack && !bus.mem_we;
        if (bus.mem_req && bus.mem_ack) begin
          if (exp_mem_q.size() == 0) begin
            fail_now("mem_unexpected");
          end else begin
            e = exp_mem_q.pop_front();
            chk("mem_we", 32'(bus.mem_we), 32'(e.we));
            chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
            if (e.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.data));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    mem_txn_t t;
    t.we   = 1'b0;
    t.addr = a;
    t.data = '0;
    exp_mem_q.push_back(t);
    exp_rd_q.push_back(d);
  endtask

  // Drive a write burst, holding each beat until stall is low at the edge.
  task automatic write_burst(input logic [ADDR_W-1:0] a, input int n,
                             input logic [DATA_W-1:0] d0, input bit push_exp,
                             output int first_stall_acc);
    mem_txn_t t;
    logic     s;
    int       tmo;
    wr_acc          = 0;
    tmo             = 0;
    first_stall_acc = -1;
    bus.sdram_cmd   = 1'b1;
    bus.sdram_we    = 1'b1;
    bus.sdram_addr  = a;
    while (wr_acc < n && tmo < 1000) begin
      bus.sdram_data = d0 + 16'(wr_acc);
      @(negedge clk);
      s = bus.stall;
      if (s && first_stall_acc < 0) first_stall_acc = wr_acc;
      tick();
      tmo++;
      if (!s) begin
        if (push_exp) begin
          t.we   = 1'b1;
          t.addr = a + 24'(wr_acc);
          t.data = d0 + 16'(wr_acc);
          exp_mem_q.push_back(t);
        end
        wr_acc++;
      end
    end
    if (wr_acc < n) fail_now("write_burst_timeout");
    bus.sdram_cmd = 1'b0;
    bus.sdram_we  = 1'b0;
  endtask

  // Hold a read burst until n words have returned, then drop sdram_cmd.
  task automatic read_burst(input logic [ADDR_W-1:0] a, input int n);
    int got;
    int tmo;
    got            = 0;
    tmo            = 0;
    bus.sdram_cmd  = 1'b1;
    bus.sdram_we   = 1'b0;
    bus.sdram_addr = a;
    while (got < n && tmo < 1000) begin
      @(negedge clk);
      tmo++;
      if (bus.rd_valid) got++;
    end
    bus.sdram_cmd = 1'b0;
    if (got < n) fail_now("read_burst_timeout");
    tick();
  endtask

  initial begin
    int fs;
    int tmo;
    int req_seen;

    reset          = 1'b0;
    mdl_clr        = 1'b1;
    ack_en         = 1'b0;
    bus.sdram_cmd  = 1'b0;
    bus.sdram_we   = 1'b0;
    bus.sdram_addr = '0;
    bus.sdram_data = '0;
    repeat (3) tick();

    // Reset values.
    chk("rst_stall", 32'(bus.stall), 32'd1);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);

    // Init wait: ready/stall flip on exactly the INIT_C-th edge after release.
    reset   = 1'b1;
    mdl_clr = 1'b0;
    for (int k = 1; k <= int'(INIT_C); k++) begin
      tick();
      if (k == int'(INIT_C) - 1) begin
        chk("init_ready_early", 32'(bus.ready), 32'd0);
        chk("init_stall_early", 32'(bus.stall), 32'd1);
      end
    end
    chk("init_ready", 32'(bus.ready), 32'd1);
    chk("init_stall", 32'(bus.stall), 32'd0);

    // Write burst of 8 at 0x100, data 1..8, ack always high.
    ack_en = 1'b1;
    write_burst(24'h000100, 8, 16'd1, 1'b1, fs);
    repeat (30) tick();
    chk("burst8_drained", 32'(exp_mem_q.size()), 32'd0);

    // Write burst of 20 against a blocked backend, then release it.
    ack_en = 1'b0;
    fork
      write_burst(24'h000300, 20, 16'h0300, 1'b1, fs);
      begin
        repeat (40) tick();
        chk("full_stall", 32'(bus.stall), 32'd1);
        chk("full_accepted", 32'(wr_acc), 32'(DEPTH - 1));
        ack_en = 1'b1;
      end
    join
    chk("first_stall_at", 32'(fs), 32'(DEPTH - 1));
    repeat (60) tick();
    chk("burst20_drained", 32'(exp_mem_q.size()), 32'd0);
    chk("burst20_stall_low", 32'(bus.stall), 32'd0);

    // Write 4 at 0x10 then read them back; the read must wait for the drain.
    write_burst(24'h000010, 4, 16'hA0, 1'b1, fs);
    tick();
    for (int i = 0; i < 4; i++) exp_read(24'h000010 + 24'(i), 16'hA0 + 16'(i));
    bus.sdram_cmd  = 1'b1;
    bus.sdram_we   = 1'b0;
    bus.sdram_addr = 24'h000010;
    tick();
    chk("raw_stall_held", 32'(bus.stall), 32'd1);
    read_burst(24'h000010, 4);
    repeat (5) tick();
    chk("raw_rd_done", 32'(exp_rd_q.size()), 32'd0);

    // Read 3 across the top of the address space.
    exp_read(24'hFFFFFE, 16'hC3FE);
    exp_read(24'hFFFFFF, 16'hC3FF);
`ifdef SDRAM_RESP_PAGE_WRAP_EN
    exp_read(24'hFFFC00, 16'hC000);
`else
    exp_read(24'h000000, 16'hC000);
`endif
    read_burst(24'hFFFFFE, 3);
    repeat (5) tick();
    chk("wrap_rd_done", 32'(exp_rd_q.size()), 32'd0);

    // Drop sdram_cmd while a read is outstanding: that word still returns.
    ack_en = 1'b0;
    exp_read(24'h000200, 16'hC200);
    bus.sdram_cmd  = 1'b1;
    bus.sdram_we   = 1'b0;
    bus.sdram_addr = 24'h000200;
    tmo = 0;
    while (!bus.mem_req && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (!bus.mem_req) fail_now("drop_req_timeout");
    bus.sdram_cmd = 1'b0;
    repeat (3) tick();
    ack_en = 1'b1;
    repeat (6) tick();
    chk("drop_rd_done", 32'(exp_rd_q.size()), 32'd0);
    chk("drop_no_req", 32'(bus.mem_req), 32'd0);

    // Reset in the middle of a write burst with 5 words buffered.
    ack_en = 1'b0;
    write_burst(24'h000080, 5, 16'h0055, 1'b0, fs);
    bus.sdram_cmd = 1'b1;
    bus.sdram_we  = 1'b1;
    reset         = 1'b0;
    #1;
    chk("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("mid_rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("mid_rst_stall", 32'(bus.stall), 32'd1);
    chk("mid_rst_ready", 32'(bus.ready), 32'd0);
    chk("mid_rst_rd_data", 32'(bus.rd_data), 32'd0);
    bus.sdram_cmd = 1'b0;
    bus.sdram_we  = 1'b0;
    ack_en        = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    repeat (INIT_C + 2) tick();
    chk("rerst_ready", 32'(bus.ready), 32'd1);
    chk("rerst_stall", 32'(bus.stall), 32'd0);
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_req) req_seen++;
    end
    chk("rerst_no_mem_req", 32'(req_seen), 32'd0);

    repeat (5) tick();
    chk("end_mem_queue", 32'(exp_mem_q.size()), 32'd0);
    chk("end_rd_queue", 32'(exp_rd_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
